rndgen_sched: RTL and testbench

- Shared random-number server: one Fibonacci XNOR LFSR, configured from a `rndgen_pkg::RndGenParams_t` setting, is time-shared between REQ_N requesters.
- Round-robin arbitration picks one requester. The LFSR then steps DATA_W times to assemble one word, which is returned to the granted requester with a one-hot grant.
- Also handles runtime reseeding and rejects the lock-up seed.
- Sits between the rndgen settings package and any test-pattern, scrambler or dither consumers.

---
 rtl/rndgen_pkg.sv | 43 ++++
 rtl/rndgen_lfsr.sv | 35 +++
 rtl/rndgen_sched.sv | 181 ++++++++++++++++++
 tb/tb_rndgen_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rndgen_pkg.sv
// Settings package for the random-number generators: LFSR parameter sets,
// the shared XNOR feedback function and the scheduler state type.
package rndgen_pkg;

    localparam int RNDGEN_MAX_LEN  = 64;
    localparam int RNDGEN_MAX_TAPS = 8;

    // TapeNum is the register length; FB holds 1-based tap positions,
    // zero entries are unused slots.
    typedef struct packed {
        logic [7:0]                          TapeNum;
        logic [RNDGEN_MAX_TAPS-1:0][7:0]     FB;
    } RndGenParams_t;

    localparam RndGenParams_t RndGen8 = '{
        TapeNum: 8'd8,
        FB:      {8'd0, 8'd0, 8'd0, 8'd3, 8'd4, 8'd5, 8'd6, 8'd8}
    };

    localparam RndGenParams_t RndGen31 = '{
        TapeNum: 8'd31,
        FB:      {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd28, 8'd31}
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } rndgen_state_t;

    // XNOR feedback: inverted parity of the tapped bits.
    function automatic logic rndgen_fb(RndGenParams_t p, logic [63:0] s);
        logic x;
        x = 1'b0;
        for (int i = 0; i < RNDGEN_MAX_TAPS; i++) begin
            if (p.FB[i] != 8'd0) begin
                x = x ^ s[6'(p.FB[i] - 8'd1)];
            end
        end
        return ~x;
    endfunction

endpackage

// File: rtl/rndgen_lfsr.sv
// Fibonacci XNOR LFSR with synchronous load; usable on its own.
module rndgen_lfsr
    import rndgen_pkg::*;
#(
    parameter RndGenParams_t                P        = RndGen31,
    parameter logic [RNDGEN_MAX_LEN-1:0]    SEED_RST = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step,
    input  logic                    load,
    input  logic [P.TapeNum-1:0]    load_val,
    output logic [P.TapeNum-1:0]    state,
    output logic                    fb
);

    localparam int LEN = int'(P.TapeNum);

    // Feedback is purely combinational on the current register contents.
    always_comb begin
        fb = rndgen_fb(P, 64'(state));
    end

    // Load wins over step so a reseed is never mixed with a shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_RST[LEN-1:0];
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= LEN'({state, fb});
        end
    end

endmodule

// File: rtl/rndgen_sched.sv
// Shared random-number server: round-robin arbitration over REQ_N
// requesters, one DATA_W-bit word assembled from DATA_W LFSR steps per grant.
//
// Handshake: req[i] is a level held until gnt[i]; gnt is one-hot and only
// high in the single cycle valid_out=1, when data_out carries the word.
// There is no backpressure: the requester must take the word in that cycle.
module rndgen_sched
    import rndgen_pkg::*;
#(
    parameter RndGenParams_t                P        = RndGen31,
    parameter int                           REQ_N    = 4,
    parameter int                           DATA_W   = 16,
    parameter logic [RNDGEN_MAX_LEN-1:0]    SEED_RST = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [REQ_N-1:0]        req,
    input  logic                    seed_load,
    input  logic [P.TapeNum-1:0]    seed_val,
    output logic [REQ_N-1:0]        gnt,
    output logic [DATA_W-1:0]       data_out,
    output logic                    valid_out,
    output logic                    busy,
    output logic                    seed_err
);

    localparam int LEN = int'(P.TapeNum);
    localparam int IW  = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam int CW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [LEN-1:0] LOCKUP = '1;

    rndgen_state_t          state;
    rndgen_state_t          state_nx;
    logic [IW-1:0]          rr;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          pick;
    logic                   pick_vld;
    logic [2*REQ_N-1:0]     req_rot;
    logic [CW-1:0]          cnt;
    logic [DATA_W-1:0]      data;
    logic [DATA_W-1:0]      data_nx;
    logic                   pend;
    logic [LEN-1:0]         pend_val;
    logic [LEN-1:0]         seed_eff;
    logic                   seed_req;
    logic                   seed_bad;
    logic                   lfsr_load;
    logic                   lfsr_step;
    logic                   last_step;
    logic [LEN-1:0]         lfsr;
    logic                   fb;

    rndgen_lfsr #(
        .P        (P),
        .SEED_RST (SEED_RST)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (lfsr_step),
        .load     (lfsr_load),
        .load_val (seed_eff),
        .state    (lfsr),
        .fb       (fb)
    );

    // Round-robin pick: rotate req so the rr pointer sits at bit 0, take the
    // lowest set bit, then map the offset back to a requester index.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        req_rot  = {req, req} >> rr;
        for (int i = 0; i < REQ_N; i++) begin
            if (!pick_vld && req_rot[i]) begin
                pick_vld = 1'b1;
                pick     = IW'((int'(rr) + i) % REQ_N);
            end
        end
    end

    // Seed handling: a seed (current pulse beats an older pending one) is
    // only applied in IDLE; the lock-up value is refused. Rewriting the
    // value the register already holds is skipped as a no-op.
    always_comb begin
        seed_req  = (state == IDLE) && (seed_load || pend);
        seed_eff  = seed_load ? seed_val : pend_val;
        seed_bad  = (seed_eff == LOCKUP);
        lfsr_load = seed_req && !seed_bad && (seed_eff != lfsr);
        data_nx   = DATA_W'({data, fb});
    end

    // Next-state logic; a seed request holds off arbitration for a cycle.
    always_comb begin
        state_nx  = state;
        lfsr_step = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (!seed_req && pick_vld) begin
                    state_nx = GEN;
                end
            end
            GEN: begin
                lfsr_step = 1'b1;
                if (cnt == CW'(DATA_W - 1)) begin
                    last_step = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr        <= '0;
            idx       <= '0;
            cnt       <= '0;
            data      <= '0;
            data_out  <= '0;
            gnt       <= '0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            seed_err  <= 1'b0;
            pend      <= 1'b0;
            pend_val  <= '0;
        end else begin
            seed_err <= seed_req && seed_bad;
            busy     <= (state_nx != IDLE);

            if (state != IDLE && seed_load) begin
                pend     <= 1'b1;
                pend_val <= seed_val;
            end else if (seed_req) begin
                pend     <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (state_nx == GEN) begin
                        idx <= pick;
                        cnt <= '0;
                    end
                end
                GEN: begin
                    data <= data_nx;
                    cnt  <= cnt + 1'b1;
                    if (last_step) begin
                        data_out  <= data_nx;
                        valid_out <= 1'b1;
                        gnt       <= REQ_N'(1) << idx;
                    end
                end
                DONE: begin
                    valid_out <= 1'b0;
                    gnt       <= '0;
                    rr        <= (int'(idx) == REQ_N - 1) ? '0 : idx + 1'b1;
                end
                default: begin
                    valid_out <= 1'b0;
                    gnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rndgen_sched.sv
// Self-checking bench for rndgen_sched with the 8-bit LFSR setting.
module tb_rndgen_sched;
    import rndgen_pkg::*;

    localparam int REQ_N  = 4;
    localparam int DATA_W = 8;
    localparam int LAT    = DATA_W + 1;

    logic               clk;
    logic               rst_n;
    logic [REQ_N-1:0]   req;
    logic               seed_load;
    logic [7:0]         seed_val;
    logic [REQ_N-1:0]   gnt;
    logic [DATA_W-1:0]  data_out;
    logic               valid_out;
    logic               busy;
    logic               seed_err;

    rndgen_sched #(
        .P        (RndGen8),
        .REQ_N    (REQ_N),
        .DATA_W   (DATA_W),
        .SEED_RST ('0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .gnt       (gnt),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
        .seed_err  (seed_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;
    int exp_err  = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [REQ_N-1:0]  gnt_q[$];

    // seed_err pulse monitor
    always @(negedge clk) begin
        if (seed_err) err_seen++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_lfsr;
    int         m_rr;

    function automatic logic [7:0] tap_mask();
        int taps[5] = '{8, 6, 5, 4, 3};
        logic [7:0] m;
        m = '0;
        foreach (taps[k]) m[taps[k]-1] = 1'b1;
        return m;
    endfunction

    // next word: DATA_W steps of feedback = NOT(parity of tapped bits)
    function automatic logic [7:0] m_word();
        logic [7:0] w;
        logic       f;
        w = '0;
        for (int s = 0; s < DATA_W; s++) begin
            f      = ~(^(m_lfsr & tap_mask()));
            m_lfsr = {m_lfsr[6:0], f};
            w      = {w[6:0], f};
        end
        return w;
    endfunction

    // first requester at or after the pointer, wrapping; pointer then moves past it
    function automatic int m_grant(logic [3:0] r);
        for (int k = 0; k < REQ_N; k++) begin
            if (r[(m_rr + k) % REQ_N]) begin
                int j;
                j    = (m_rr + k) % REQ_N;
                m_rr = (j + 1) % REQ_N;
                return j;
            end
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        seed_load = 1'b0;
        seed_val  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_lfsr = 8'h00;
        m_rr   = 0;
    endtask

    task automatic wait_valid(input string nm, inout int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            lat++;
            n++;
        end while (!valid_out && n < 200);
        if (!valid_out) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no valid_out after %0d cycles", nm, n);
        end
    endtask

    // one transaction: opt 0 plain, 1 seed with req, 2 seed mid-word, 3 drop req early
    task automatic run_txn(input logic [3:0] r, input int opt, input logic [7:0] sv,
                           input int off, output int lat);
        int n;
        req = r;
        if (opt == 1) begin
            seed_load = 1'b1;
            seed_val  = sv;
        end
        lat = 0;
        n   = 0;
        do begin
            @(negedge clk);
            lat++;
            n++;
            if (opt == 1 && lat == 1) seed_load = 1'b0;
            if (opt == 2 && lat == off) begin
                seed_load = 1'b1;
                seed_val  = sv;
            end
            if (opt == 2 && lat == off + 1) seed_load = 1'b0;
            if (opt == 3 && lat == 2) req = '0;
        end while (!valid_out && n < 200);
        if (!valid_out) begin
            total++;
            bad++;
            $display("FAIL txn_timeout: no valid_out after %0d cycles", n);
        end
    endtask

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int lat;
        logic [7:0] ed;
        logic [3:0] eg;
        logic [7:0] sv;
        logic [7:0] prev_data;

        // ---- reset state ----
        do_reset();
        check("rst_valid", valid_out, 1'b0);
        check("rst_gnt", gnt, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_seed_err", seed_err, 1'b0);
        check("rst_data", data_out, 8'h00);

        // ---- sequence check from SEED_RST=0 ----
        req = 4'b0001;
        lat = 0;
        @(negedge clk);
        lat++;
        check("seq_busy", busy, 1'b1);
        wait_valid("seq", lat);
        check("seq_lat", lat, LAT);
        check("seq_data", data_out, 8'hE8);
        check("seq_gnt", gnt, 4'b0001);
        req = '0;
        @(negedge clk);
        check("seq_valid_drop", valid_out, 1'b0);
        check("seq_gnt_drop", gnt, 4'h0);
        check("seq_data_hold", data_out, 8'hE8);

        // ---- round robin with all requests held ----
        do_reset();
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            lat = 0;
            ed  = m_word();
            eg  = 4'(1 << m_grant(4'hF));
            wait_valid("rr", lat);
            check($sformatf("rr%0d_lat", k), lat, (k == 0) ? LAT : DATA_W + 2);
            check($sformatf("rr%0d_gnt", k), gnt, eg);
            check($sformatf("rr%0d_data", k), data_out, ed);
        end
        req = '0;
        repeat (2) @(negedge clk);

        // ---- table-driven arbitration from reset ----
        do_reset();
        tbl[0] = '{4'b0001, 4'b0001, 8'h00};
        tbl[1] = '{4'b0001, 4'b0001, 8'h00};
        tbl[2] = '{4'b1001, 4'b1000, 8'h00};
        tbl[3] = '{4'b0110, 4'b0010, 8'h00};
        tbl[4] = '{4'b0011, 4'b0001, 8'h00};
        tbl[5] = '{4'b1111, 4'b0010, 8'h00};
        tbl[6] = '{4'b0100, 4'b0100, 8'h00};
        tbl[7] = '{4'b1010, 4'b1000, 8'h00};
        foreach (tbl[i]) tbl[i].d = m_word();
        foreach (tbl[i]) begin
            req = tbl[i].r;
            lat = 0;
            wait_valid("tbl", lat);
            check($sformatf("tbl%0d_lat", i), lat, LAT);
            check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].g);
            check($sformatf("tbl%0d_data", i), data_out, tbl[i].d);
            req = '0;
            repeat (2) @(negedge clk);
        end

        // ---- reseed mid-word ----
        do_reset();
        req = 4'b0001;
        lat = 0;
        repeat (3) begin
            @(negedge clk);
            lat++;
        end
        seed_load = 1'b1;
        seed_val  = 8'h01;
        @(negedge clk);
        lat++;
        seed_load = 1'b0;
        wait_valid("reseed", lat);
        check("reseed_cur_lat", lat, LAT);
        check("reseed_cur_data", data_out, 8'hE8);
        req = '0;
        repeat (2) @(negedge clk);
        m_lfsr = 8'h01;
        ed = m_word();
        req = 4'b0001;
        lat = 0;
        wait_valid("reseed_next", lat);
        check("reseed_next_data", data_out, 8'hD0);
        check("reseed_next_model", data_out, ed);
        req = '0;
        repeat (2) @(negedge clk);

        // ---- lock-up seed in IDLE ----
        seed_load = 1'b1;
        seed_val  = 8'hFF;
        @(negedge clk);
        seed_load = 1'b0;
        exp_err++;
        check("lockup_err_pulse", seed_err, 1'b1);
        @(negedge clk);
        check("lockup_err_end", seed_err, 1'b0);
        ed = m_word();
        req = 4'b0010;
        lat = 0;
        wait_valid("lockup", lat);
        check("lockup_lat", lat, LAT);
        check("lockup_data", data_out, ed);
        req = '0;
        repeat (2) @(negedge clk);

        // ---- seed_load together with req in IDLE ----
        m_lfsr = 8'h5A;
        ed = m_word();
        req       = 4'b0100;
        seed_load = 1'b1;
        seed_val  = 8'h5A;
        lat = 0;
        @(negedge clk);
        lat++;
        seed_load = 1'b0;
        check("simul_not_busy", busy, 1'b0);
        wait_valid("simul", lat);
        check("simul_lat", lat, DATA_W + 2);
        check("simul_data", data_out, ed);
        req = '0;
        repeat (2) @(negedge clk);

        // ---- reset in the middle of a word ----
        prev_data = data_out;
        req = 4'b0001;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_prev_nonzero", (prev_data != 8'h00), 1'b1);
        check("midrst_valid", valid_out, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_gnt", gnt, 4'h0);
        check("midrst_data", data_out, 8'h00);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_lfsr = 8'h00;
        m_rr   = 0;
        req = 4'b0001;
        lat = 0;
        wait_valid("midrst", lat);
        check("midrst_lat", lat, LAT);
        check("midrst_data_again", data_out, 8'hE8);
        req = '0;
        repeat (2) @(negedge clk);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int n = 0; n < 40; n++) begin
            int opt;
            int off;
            logic [3:0] r;
            opt = $urandom_range(0, 3);
            r   = 4'($urandom_range(1, 15));
            sv  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) sv = 8'hFF;
            off = $urandom_range(1, DATA_W - 1);
            if (opt == 1) begin
                if (sv == 8'hFF) exp_err++;
                else m_lfsr = sv;
            end
            gnt_q.push_back(4'(1 << m_grant(r)));
            exp_q.push_back(m_word());
            if (opt == 2) begin
                if (sv == 8'hFF) exp_err++;
                else m_lfsr = sv;
            end
            run_txn(r, opt, sv, off, lat);
            check($sformatf("rnd%0d_lat", n), lat, (opt == 1) ? DATA_W + 2 : LAT);
            check($sformatf("rnd%0d_gnt", n), gnt, gnt_q.pop_front());
            check($sformatf("rnd%0d_data", n), data_out, exp_q.pop_front());
            req = '0;
            repeat (2) @(negedge clk);
        end

        check("seed_err_count", err_seen, exp_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
